// File: rtl/dc_fill_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : dc_fill_ctrl
// Brief    : Data-cache miss/fill controller. It stalls the core, requests a
//            line and streams the returned beats into the cache data array.
//            Optional memory timeout with sticky error: DC_FILL_TIMEOUT_EN.
// Revision : 1.0
// ============================================================================
module dc_fill_ctrl #(
  parameter int ADDR_W      = 20,
  parameter int DATA_W      = 32,
  parameter int LINE_WORDS  = 8,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic              core_rd_en,
  input  logic              core_wr_en,
  input  logic              dc_miss,
  input  logic              dc_seg_fault,
  output logic              stall,
  output logic              mem_req_valid,
  output logic [ADDR_W-1:0] mem_req_addr,
  input  logic              mem_req_ready,
  input  logic              mem_rsp_valid,
  input  logic [DATA_W-1:0] mem_rsp_data,
  output logic              fill_we,
  output logic [ADDR_W-1:0] fill_addr,
  output logic [DATA_W-1:0] fill_data,
  output logic              fill_done,
  output logic              fill_err
);

  localparam int CNT_W = $clog2(LINE_WORDS);
  localparam logic [ADDR_W-1:0] C_LINE_MASK = ADDR_W'(LINE_WORDS * 4 - 1);
  localparam logic [CNT_W-1:0]  C_LAST_BEAT = CNT_W'(LINE_WORDS - 1);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_REQ   = 3'd1;
  localparam logic [2:0] ST_BURST = 3'd2;
  localparam logic [2:0] ST_DONE  = 3'd3;
`ifdef DC_FILL_TIMEOUT_EN
  localparam logic [2:0] ST_ERR   = 3'd4;
  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TMO_W-1:0] C_TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);
  logic [TMO_W-1:0] r_tmo;
`endif

  logic [2:0]        r_state;
  logic [ADDR_W-1:0] r_base;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_fill_we;
  logic [ADDR_W-1:0] r_fill_addr;
  logic [DATA_W-1:0] r_fill_data;
  logic              w_miss_start;

  assign w_miss_start = (r_state == ST_IDLE) & dc_miss & (core_rd_en | core_wr_en) & ~dc_seg_fault;

  // stall must cover the miss cycle itself, before the FSM has left IDLE
  assign stall         = (r_state != ST_IDLE) | w_miss_start;
  assign mem_req_valid = (r_state == ST_REQ);
  assign mem_req_addr  = (r_state == ST_REQ) ? r_base : '0;
  assign fill_we       = r_fill_we;
  assign fill_addr     = r_fill_addr;
  assign fill_data     = r_fill_data;
  assign fill_done     = (r_state == ST_DONE);
`ifdef DC_FILL_TIMEOUT_EN
  assign fill_err      = (r_state == ST_ERR);
`else
  assign fill_err      = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_base      <= '0;
      r_cnt       <= '0;
      r_fill_we   <= 1'b0;
      r_fill_addr <= '0;
      r_fill_data <= '0;
`ifdef DC_FILL_TIMEOUT_EN
      r_tmo       <= '0;
`endif
    end else begin
      r_fill_we <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_miss_start) begin
            r_base  <= core_addr & ~C_LINE_MASK;
            r_state <= ST_REQ;
`ifdef DC_FILL_TIMEOUT_EN
            r_tmo   <= '0;
`endif
          end
        end
        ST_REQ: begin
          if (mem_req_ready) begin
            r_cnt   <= '0;
            r_state <= ST_BURST;
`ifdef DC_FILL_TIMEOUT_EN
            r_tmo   <= '0;
          end else if (r_tmo == C_TMO_LAST) begin
            r_state <= ST_ERR;
          end else begin
            r_tmo   <= r_tmo + 1'b1;
`endif
          end
        end
        ST_BURST: begin
          if (mem_rsp_valid) begin
            r_fill_we   <= 1'b1;
            r_fill_data <= mem_rsp_data;
            // base has its offset bits cleared, so OR acts as the add
            r_fill_addr <= r_base | ADDR_W'({r_cnt, 2'b00});
            r_cnt       <= r_cnt + 1'b1;
            if (r_cnt == C_LAST_BEAT) r_state <= ST_DONE;
`ifdef DC_FILL_TIMEOUT_EN
            r_tmo       <= '0;
          end else if (r_tmo == C_TMO_LAST) begin
            r_state <= ST_ERR;
          end else begin
            r_tmo   <= r_tmo + 1'b1;
`endif
          end
        end
        ST_DONE: r_state <= ST_IDLE;
`ifdef DC_FILL_TIMEOUT_EN
        ST_ERR:  r_state <= ST_ERR;
`endif
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dc_fill_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_dc_fill_ctrl
// Brief    : Directed self-checking bench for dc_fill_ctrl.
// Revision : 1.0
// ============================================================================
module tb_dc_fill_ctrl;

  localparam int ADDR_W = 20;
  localparam int DATA_W = 32;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [ADDR_W-1:0] core_addr = '0;
  logic              core_rd_en = 1'b0;
  logic              core_wr_en = 1'b0;
  logic              dc_miss = 1'b0;
  logic              dc_seg_fault = 1'b0;
  logic              stall;
  logic              mem_req_valid;
  logic [ADDR_W-1:0] mem_req_addr;
  logic              mem_req_ready = 1'b0;
  logic              mem_rsp_valid = 1'b0;
  logic [DATA_W-1:0] mem_rsp_data = '0;
  logic              fill_we;
  logic [ADDR_W-1:0] fill_addr;
  logic [DATA_W-1:0] fill_data;
  logic              fill_done;
  logic              fill_err;

  int n_checks = 0;
  int n_errors = 0;

  dc_fill_ctrl #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LINE_WORDS(8), .TIMEOUT_CYC(16)
  ) dut (
    .clk(clk), .rst_n(rst_n), .core_addr(core_addr), .core_rd_en(core_rd_en),
    .core_wr_en(core_wr_en), .dc_miss(dc_miss), .dc_seg_fault(dc_seg_fault),
    .stall(stall), .mem_req_valid(mem_req_valid), .mem_req_addr(mem_req_addr),
    .mem_req_ready(mem_req_ready), .mem_rsp_valid(mem_rsp_valid),
    .mem_rsp_data(mem_rsp_data), .fill_we(fill_we), .fill_addr(fill_addr),
    .fill_data(fill_data), .fill_done(fill_done), .fill_err(fill_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_stall"}, 32'(stall), 32'd0);
    chk({tag, "_reqv"},  32'(mem_req_valid), 32'd0);
    chk({tag, "_we"},    32'(fill_we), 32'd0);
    chk({tag, "_done"},  32'(fill_done), 32'd0);
    chk({tag, "_err"},   32'(fill_err), 32'd0);
  endtask

  // Drives one complete line fill and checks every beat against hand-derived values.
  task automatic do_fill(input logic [ADDR_W-1:0] addr, input logic [ADDR_W-1:0] exp_base,
                         input bit wr, input int rdy_dly, input bit gap,
                         input logic [31:0] d0, input bit rsp_in_req, input bit extra_beat);
    core_addr  = addr;
    core_rd_en = ~wr;
    core_wr_en = wr;
    dc_miss    = 1'b1;
    #1;
    chk("stall_comb", 32'(stall), 32'd1);
    chk("reqv_idle",  32'(mem_req_valid), 32'd0);
    tick();
    core_rd_en = 1'b0;
    core_wr_en = 1'b0;
    dc_miss    = 1'b0;
    chk("reqv", 32'(mem_req_valid), 32'd1);
    chk("req_addr", 32'(mem_req_addr), 32'(exp_base));
    for (int i = 0; i < rdy_dly; i++) begin
      if (rsp_in_req) begin
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = 32'hDEAD_0000 + 32'(i);
      end
      tick();
      mem_rsp_valid = 1'b0;
      chk("req_hold", 32'(mem_req_valid), 32'd1);
      chk("req_addr_hold", 32'(mem_req_addr), 32'(exp_base));
      chk("req_no_we", 32'(fill_we), 32'd0);
    end
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    chk("req_drop", 32'(mem_req_valid), 32'd0);
    chk("burst_stall", 32'(stall), 32'd1);
    for (int b = 0; b < 8; b++) begin
      mem_rsp_valid = 1'b1;
      mem_rsp_data  = d0 + 32'(b);
      tick();
      mem_rsp_valid = 1'b0;
      chk("beat_we",   32'(fill_we), 32'd1);
      chk("beat_addr", 32'(fill_addr), 32'(exp_base) + 32'(b * 4));
      chk("beat_data", fill_data, d0 + 32'(b));
      chk("beat_done", 32'(fill_done), (b == 7) ? 32'd1 : 32'd0);
      chk("beat_stall", 32'(stall), 32'd1);
      if (gap && b < 7) begin
        tick();
        chk("gap_we", 32'(fill_we), 32'd0);
        chk("gap_done", 32'(fill_done), 32'd0);
      end
    end
    if (extra_beat) begin
      mem_rsp_valid = 1'b1;
      mem_rsp_data  = 32'hBAD0_0009;
    end
    tick();
    mem_rsp_valid = 1'b0;
    chk("post_stall", 32'(stall), 32'd0);
    chk("post_done",  32'(fill_done), 32'd0);
    chk("post_we",    32'(fill_we), 32'd0);
    tick();
    chk_quiet("idle_after");
  endtask

  initial begin
    #12;
    chk_quiet("rst");
    chk("rst_addr", 32'(fill_addr), 32'd0);
    chk("rst_req_addr", 32'(mem_req_addr), 32'd0);
    rst_n = 1'b1;
    tick();

    // read miss, ready after 2 cycles, back-to-back beats
    do_fill(20'h10234, 20'h10220, 1'b0, 2, 1'b0, 32'hA0, 1'b0, 1'b0);
    // write miss with one idle cycle between beats
    do_fill(20'h102E0, 20'h102E0, 1'b1, 1, 1'b1, 32'hB0, 1'b0, 1'b0);

    // out-of-range access must not start a fill
    core_addr = 20'h20000; core_rd_en = 1'b1; dc_miss = 1'b1; dc_seg_fault = 1'b1;
    #1;
    chk("seg_stall", 32'(stall), 32'd0);
    tick();
    chk_quiet("seg1");
    tick();
    chk("seg_reqv2", 32'(mem_req_valid), 32'd0);
    core_rd_en = 1'b0; dc_miss = 1'b0; dc_seg_fault = 1'b0;
    tick();

    // abort mid-fill with asynchronous reset
    core_addr = 20'h10400; core_rd_en = 1'b1; dc_miss = 1'b1;
    tick();
    core_rd_en = 1'b0; dc_miss = 1'b0;
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    for (int b = 0; b < 3; b++) begin
      mem_rsp_valid = 1'b1; mem_rsp_data = 32'hC0 + 32'(b);
      tick();
    end
    mem_rsp_valid = 1'b0;
    chk("pre_rst_we", 32'(fill_we), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_quiet("async_rst");
    chk("async_rst_addr", 32'(fill_addr), 32'd0);
    chk("async_rst_data", fill_data, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    do_fill(20'h10200, 20'h10200, 1'b0, 0, 1'b0, 32'hE0, 1'b0, 1'b0);

    // beats during REQ and a 9th beat after DONE are both ignored
    do_fill(20'h1F0FC, 20'h1F0E0, 1'b0, 3, 1'b0, 32'h55, 1'b1, 1'b1);

`ifdef DC_FILL_TIMEOUT_EN
    core_addr = 20'h30010; core_rd_en = 1'b1; dc_miss = 1'b1;
    tick();
    core_rd_en = 1'b0; dc_miss = 1'b0;
    for (int i = 0; i < 15; i++) tick();
    chk("tmo_not_yet", 32'(fill_err), 32'd0);
    chk("tmo_reqv", 32'(mem_req_valid), 32'd1);
    tick();
    chk("tmo_err", 32'(fill_err), 32'd1);
    chk("tmo_stall", 32'(stall), 32'd1);
    mem_req_ready = 1'b1; mem_rsp_valid = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b0;
    chk("tmo_sticky", 32'(fill_err), 32'd1);
    chk("tmo_stall_hold", 32'(stall), 32'd1);
    chk("tmo_no_we", 32'(fill_we), 32'd0);
    chk("tmo_no_done", 32'(fill_done), 32'd0);
    rst_n = 1'b0;
    #1;
    chk("tmo_rst_err", 32'(fill_err), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
